mem_access_unit: RTL and testbench

MEM-stage data-memory access controller. It sits between the EX/MEM pipeline register and MEM_WB, and drives a variable-latency data memory through a req/ready handshake. It asserts a pipeline stall while an access is outstanding and presents the load result as ReadDataMEM for MEM_WB to sample. It also flags misaligned accesses and memory timeouts.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_timeout_ctr.sv | 29 ++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEF  = 15;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit up-counter with clear/enable and a terminal-count flag at LIMIT-1.
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(LIMIT - 1);

    logic [7:0] count;

    // The owner stops enabling once tc is reached, so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues one req/ready memory access per load/store,
// stalls the pipeline while it is outstanding, flags misalignment and timeout.
//
//   state | meaning
//   IDLE  | no access outstanding; an aligned access is accepted here
//   WAIT  | mem_req held high, waiting for mem_ready or the timeout limit
//   DONE  | result registered, stall released for one cycle
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0]    ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadMEM,
    input  logic              MemWriteMEM,
    input  logic [ADDR_W-1:0] AddressMEM,
    input  logic [DATA_W-1:0] WriteDataMEM,
    output logic [DATA_W-1:0] ReadDataMEM,
    output logic              StallMEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              misalign_err,
    output logic              timeout_err
);

    state_t state, state_nxt;
    logic   access, aligned, is_load, accept;
    logic   tc, ctr_clr, ctr_en;

    assign access   = MemReadMEM | MemWriteMEM;
    assign aligned  = is_aligned(AddressMEM[1:0]);
    assign is_load  = MemReadMEM & ~MemWriteMEM;
    assign accept   = (state == IDLE) & access & aligned;
    assign StallMEM = ~rst & (accept | (state == WAIT));

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    ctr_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ready || tc) begin
                    state_nxt = DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request attributes are captured only on accept, so they stay stable while mem_req=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadDataMEM  <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWriteMEM;
                            mem_addr  <= AddressMEM & ~ADDR_W'(ALIGN_MASK);
                            mem_wdata <= WriteDataMEM;
                        end else begin
                            misalign_err <= 1'b1;
                            if (is_load) begin
                                ReadDataMEM <= '0;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadDataMEM <= mem_rdata;
                        end
                    end else if (tc) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (!mem_we) begin
                            ReadDataMEM <= ERR_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions scored against a per-transaction behavioural model.
module tb_mem_access_unit;

    localparam int          TO  = 15;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadMEM, MemWriteMEM;
    logic [31:0] AddressMEM, WriteDataMEM;
    logic [31:0] ReadDataMEM;
    logic        StallMEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        misalign_err, timeout_err;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rd;
    int          low_run = 0;
    int          last_gap = 0;
    int          rise_cnt = 0;

    mem_access_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (TO),
        .ERR_DATA (ERR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MemReadMEM   (MemReadMEM),
        .MemWriteMEM  (MemWriteMEM),
        .AddressMEM   (AddressMEM),
        .WriteDataMEM (WriteDataMEM),
        .ReadDataMEM  (ReadDataMEM),
        .StallMEM     (StallMEM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Length of each mem_req-low gap, measured in cycles before a new request burst.
    always @(negedge clk) begin
        if (rst) begin
            low_run <= 0;
        end else if (mem_req) begin
            if (low_run > 0) begin
                last_gap <= low_run;
                rise_cnt <= rise_cnt + 1;
            end
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Entered and left just after a rising edge with the unit idle.
    // lat = WAIT cycle on which mem_ready is given (1..TO); anything else means never.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int lat, input logic [31:0] rdv);
        bit is_load, timed_out;
        int exp_wait, stalls, waits;
        is_load      = rd && !wr;
        MemReadMEM   = rd;
        MemWriteMEM  = wr;
        AddressMEM   = addr;
        WriteDataMEM = wd;
        mem_ready    = 1'b0;
        mem_rdata    = $urandom;
        if (addr[1:0] != 2'b00) begin
            if (is_load) exp_rd = 32'h0;
            @(negedge clk);
            chk1("mis_stall", StallMEM, 1'b0);
            chk1("mis_req", mem_req, 1'b0);
            @(posedge clk); #1;
            MemReadMEM  = 1'b0;
            MemWriteMEM = 1'b0;
            @(negedge clk);
            chk1("mis_err", misalign_err, 1'b1);
            chk1("mis_req2", mem_req, 1'b0);
            chk("mis_rdata", ReadDataMEM, exp_rd);
            @(posedge clk); #1;
            @(negedge clk);
            chk1("mis_pulse_end", misalign_err, 1'b0);
            @(posedge clk); #1;
        end else begin
            timed_out = (lat < 1) || (lat > TO);
            exp_wait  = timed_out ? TO : lat;
            if (is_load) exp_rd = timed_out ? ERR : rdv;
            stalls = 0;
            waits  = 0;
            @(negedge clk);
            chk1("idle_req", mem_req, 1'b0);
            if (StallMEM) stalls++;
            for (int k = 1; k <= TO + 2; k++) begin
                @(posedge clk); #1;
                if (mem_req !== 1'b1) break;
                waits++;
                mem_ready = (k == lat);
                mem_rdata = (k == lat) ? rdv : $urandom;
                @(negedge clk);
                if (StallMEM) stalls++;
                chk("req_addr", mem_addr, addr);
                chk("req_wdata", mem_wdata, wd);
                chk1("req_we", mem_we, wr);
                chk1("wait_tmo", timeout_err, 1'b0);
                if (k == TO + 2) begin
                    @(posedge clk); #1;
                end
            end
            mem_ready = 1'b0;
            chk("wait_cycles", waits, exp_wait);
            @(negedge clk);
            chk1("done_stall", StallMEM, 1'b0);
            chk1("done_req", mem_req, 1'b0);
            chk1("done_tmo", timeout_err, timed_out);
            chk("done_rdata", ReadDataMEM, exp_rd);
            chk("stall_cycles", stalls, exp_wait + 1);
            @(posedge clk); #1;
            MemReadMEM  = 1'b0;
            MemWriteMEM = 1'b0;
        end
    endtask

    initial begin
        int          r0;
        logic [31:0] ra, rw, rv;
        int          op, lat;

        rst          = 1'b1;
        MemReadMEM   = 1'b1;
        MemWriteMEM  = 1'b0;
        AddressMEM   = 32'h0;
        WriteDataMEM = 32'h0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;
        exp_rd       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_stall", StallMEM, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", ReadDataMEM, 32'h0);
        chk1("rst_mis", misalign_err, 1'b0);
        chk1("rst_tmo", timeout_err, 1'b0);
        MemReadMEM = 1'b0;
        rst        = 1'b0;
        @(posedge clk); #1;

        do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h12345678);
        do_access(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 3, 32'h0BADBAD0);
        do_access(1'b1, 1'b0, 32'h42, 32'h0, 1, 32'h0);
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h0);
        do_access(1'b1, 1'b0, 32'h48, 32'h0, TO, 32'h600DF00D);
        do_access(1'b1, 1'b1, 32'h10, 32'h13572468, 2, 32'h99999999);
        do_access(1'b0, 1'b1, 32'h23, 32'h1, 1, 32'h0);

        // Reset while a load sits in its second WAIT cycle.
        MemReadMEM = 1'b1;
        AddressMEM = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("midrst_pre_req", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("midrst_req", mem_req, 1'b0);
        chk1("midrst_stall", StallMEM, 1'b0);
        MemReadMEM = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk1("stale_ready_req", mem_req, 1'b0);
        chk1("stale_ready_stall", StallMEM, 1'b0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        exp_rd    = 32'h0;
        @(negedge clk);
        chk("stale_ready_rdata", ReadDataMEM, 32'h0);
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 2, 32'hA5A5F00F);

        // Back-to-back loads: one DONE plus one IDLE cycle between bursts.
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h11111111);
        r0 = rise_cnt;
        do_access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h22222222);
        chk("b2b_rises", rise_cnt - r0, 1);
        chk("b2b_gap", last_gap, 2);

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 2);
            ra = $urandom;
            ra = ra & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) ra = ra | 32'(2'($urandom_range(1, 3)));
            rw  = $urandom;
            rv  = $urandom;
            lat = $urandom_range(0, TO);
            do_access(op != 1, op != 0, ra, rw, lat, rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
